// File: rtl/fp_posit_pkg.sv
// Shared FSM state encoding and derived-width helpers for the posit-weight x FP-activation multiplier.
package fp_posit_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SIGN,
        REGIME,
        EXPO,
        FRAC,
        DONE
    } state_t;

    localparam int CNT_W = 4;

    function automatic int frac_max_f(input int prec_max, input int es);
        return prec_max - 3 - es;
    endfunction

    function automatic int mant_out_w_f(input int man_w, input int prec_max, input int es);
        return man_w + 1 + frac_max_f(prec_max, es);
    endfunction

    function automatic int oexp_w_f(input int exp_w);
        return exp_w + 4;
    endfunction

endpackage

// File: rtl/fp_posit_lane.sv
// One activation lane: captures act, accumulates shifted mantissa copies, adds the weight scale to the exponent.
// Build option FP_POSIT_ACT_SPECIAL_EN: act exponent 0 / all-ones raise zero_out / nar_out.
module fp_posit_lane
    import fp_posit_pkg::*;
#(
    parameter int ACT_WIDTH  = 16,
    parameter int EXP_WIDTH  = 5,
    parameter int MAN_WIDTH  = 10,
    parameter int FRAC_MAX   = 5,
    parameter int MANT_OUT_W = 16,
    parameter int OEXP_W     = 9
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ACT_WIDTH-1:0]  act,
    input  logic                  add_en,
    input  logic [CNT_W-1:0]      add_sh,
    input  logic                  fin,
    input  logic [OEXP_W-1:0]     scale,
    input  logic                  w_sign,
    input  logic                  w_zero,
    input  logic                  w_nar,
    output logic                  sign_out,
    output logic [OEXP_W-1:0]     exp_out,
    output logic [MANT_OUT_W-1:0] mant_out,
    output logic                  zero_out,
    output logic                  nar_out
);

    logic                        a_sign;
    logic [EXP_WIDTH-1:0]        a_exp;
    logic [MAN_WIDTH:0]          a_man;
    logic [MANT_OUT_W-1:0]       acc;
    logic [MANT_OUT_W-1:0]       acc_n;
    logic [MANT_OUT_W-1:0]       addend;
    logic signed [OEXP_W-1:0]    exp_sum;
    logic                        act_zero;
    logic                        act_nar;
    logic                        lane_zero;
    logic                        lane_nar;

    // Accumulator is kept at the output width; a full-scale mantissa with every fraction bit set wraps.
    assign addend  = MANT_OUT_W'(a_man) << add_sh;
    assign acc_n   = add_en ? acc + addend : acc;
    assign exp_sum = $signed({{(OEXP_W-EXP_WIDTH){1'b0}}, a_exp}) + $signed(scale);

`ifdef FP_POSIT_ACT_SPECIAL_EN
    assign act_zero = (a_exp == '0);
    assign act_nar  = (a_exp == '1);
`else
    assign act_zero = 1'b0;
    assign act_nar  = 1'b0;
`endif

    assign lane_nar  = w_nar | act_nar;
    assign lane_zero = (w_zero | act_zero) & ~lane_nar;

    always_ff @(posedge clk) begin
        if (start) begin
            a_sign <= act[ACT_WIDTH-1];
            a_exp  <= act[MAN_WIDTH +: EXP_WIDTH];
            a_man  <= {1'b1, act[MAN_WIDTH-1:0]};
            acc    <= MANT_OUT_W'({1'b1, act[MAN_WIDTH-1:0]}) << FRAC_MAX;
        end else if (add_en) begin
            acc    <= acc_n;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sign_out <= 1'b0;
            exp_out  <= '0;
            mant_out <= '0;
            zero_out <= 1'b0;
            nar_out  <= 1'b0;
        end else if (fin) begin
            sign_out <= a_sign ^ w_sign;
            zero_out <= lane_zero;
            nar_out  <= lane_nar;
            exp_out  <= (lane_zero | lane_nar) ? '0 : exp_sum;
            mant_out <= (lane_zero | lane_nar) ? '0 : acc_n;
        end
    end

endmodule

// File: rtl/fp_posit_mul_vec.sv
// Vector multiplier: LANES FP activations times one bit-serial posit weight (sign + posit magnitude, MSB first).
// Build option FP_POSIT_ACT_SPECIAL_EN enables per-lane act zero/NaR detection in fp_posit_lane.
module fp_posit_mul_vec
    import fp_posit_pkg::*;
#(
    parameter int LANES     = 4,
    parameter int ACT_WIDTH = 16,
    parameter int EXP_WIDTH = 5,
    parameter int MAN_WIDTH = 10,
    parameter int PREC_MAX  = 8,
    parameter int ES        = 0,
    localparam int FRAC_MAX   = frac_max_f(PREC_MAX, ES),
    localparam int MANT_OUT_W = mant_out_w_f(MAN_WIDTH, PREC_MAX, ES),
    localparam int OEXP_W     = oexp_w_f(EXP_WIDTH)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          set,
    input  logic [3:0]                    precision,
    input  logic [LANES*ACT_WIDTH-1:0]    act,
    input  logic                          act_valid,
    output logic                          act_ready,
    input  logic                          w,
    input  logic                          w_valid,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [LANES-1:0]              sign_out,
    output logic [LANES*OEXP_W-1:0]       exp_out,
    output logic [LANES*MANT_OUT_W-1:0]   mant_out,
    output logic [LANES-1:0]              zero_out,
    output logic [LANES-1:0]              nar_out
);

    localparam int ES_W = (ES > 0) ? ES : 1;
    localparam logic signed [OEXP_W-1:0] ONE_S = 1;

    state_t                   state;
    logic [CNT_W-1:0]         prec;
    logic [CNT_W-1:0]         cnt;
    logic [CNT_W-1:0]         run;
    logic [CNT_W-1:0]         fi;
    logic [1:0]               ec;
    logic [1:0]               e_sh;
    logic                     w_sign;
    logic                     reg_r;
    logic                     any_one;
    logic [ES_W-1:0]          e_acc;

    logic                     take;
    logic                     last;
    logic                     start;
    logic                     term;
    logic                     reg_r_n;
    logic [CNT_W-1:0]         run_n;
    logic [ES_W-1:0]          e_n;
    logic                     any_n;
    logic signed [OEXP_W-1:0] run_s;
    logic signed [OEXP_W-1:0] k_n;
    logic signed [OEXP_W-1:0] scale;
    logic                     add_en;
    logic [CNT_W-1:0]         add_sh;

    function automatic logic [CNT_W-1:0] clamp_prec(input logic [3:0] p);
        if (p < 4'd3)
            return 4'd3;
        if (p > 4'(PREC_MAX))
            return 4'(PREC_MAX);
        return p;
    endfunction

    assign take  = w_valid && (state inside {SIGN, REGIME, EXPO, FRAC});
    assign last  = take && (cnt == prec - 4'd1);
    assign start = (state == IDLE) && act_valid;
    assign term  = (run != '0) && (w != reg_r);
    assign e_sh  = 2'(ES_W - 1) - ec;

    // Next-value view of the decode registers, so the final bit is already folded in when results are latched.
    always_comb begin
        reg_r_n = reg_r;
        run_n   = run;
        e_n     = e_acc;
        any_n   = any_one;
        if (take && state != SIGN && w)
            any_n = 1'b1;
        if (take && state == REGIME) begin
            if (run == '0) begin
                reg_r_n = w;
                run_n   = 4'd1;
            end else if (w == reg_r) begin
                run_n   = run + 4'd1;
            end
        end
        if (take && state == EXPO && w)
            e_n = e_acc | (ES_W'(1) << e_sh);
    end

    assign run_s  = $signed({{(OEXP_W-CNT_W){1'b0}}, run_n});
    assign k_n    = reg_r_n ? run_s - ONE_S : -run_s;
    assign scale  = (k_n <<< ES) + $signed({{(OEXP_W-ES_W){1'b0}}, e_n});
    assign add_en = take && (state == FRAC) && w;
    assign add_sh = 4'(FRAC_MAX) - fi;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            prec      <= 4'(PREC_MAX);
            act_ready <= 1'b1;
            out_valid <= 1'b0;
            cnt       <= '0;
            run       <= '0;
            fi        <= '0;
            ec        <= '0;
            w_sign    <= 1'b0;
            reg_r     <= 1'b0;
            any_one   <= 1'b0;
            e_acc     <= '0;
        end else begin
            reg_r   <= reg_r_n;
            run     <= run_n;
            e_acc   <= e_n;
            any_one <= any_n;
            case (state)
                IDLE: begin
                    if (set)
                        prec <= clamp_prec(precision);
                    if (act_valid) begin
                        state     <= SIGN;
                        act_ready <= 1'b0;
                        cnt       <= '0;
                        run       <= '0;
                        reg_r     <= 1'b0;
                        e_acc     <= '0;
                        ec        <= '0;
                        fi        <= 4'd1;
                        any_one   <= 1'b0;
                    end
                end
                SIGN: if (take) begin
                    w_sign <= w;
                    cnt    <= cnt + 4'd1;
                    state  <= REGIME;
                end
                REGIME: if (take) begin
                    cnt <= cnt + 4'd1;
                    if (term)
                        state <= (ES > 0) ? EXPO : FRAC;
                end
                EXPO: if (take) begin
                    cnt <= cnt + 4'd1;
                    ec  <= ec + 2'd1;
                    if (ec == 2'(ES - 1))
                        state <= FRAC;
                end
                FRAC: if (take) begin
                    cnt <= cnt + 4'd1;
                    fi  <= fi + 4'd1;
                end
                DONE: if (out_ready) begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    act_ready <= 1'b1;
                end
                default: state <= IDLE;
            endcase
            if (last) begin
                state     <= DONE;
                out_valid <= 1'b1;
            end
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        fp_posit_lane #(
            .ACT_WIDTH  (ACT_WIDTH),
            .EXP_WIDTH  (EXP_WIDTH),
            .MAN_WIDTH  (MAN_WIDTH),
            .FRAC_MAX   (FRAC_MAX),
            .MANT_OUT_W (MANT_OUT_W),
            .OEXP_W     (OEXP_W)
        ) u_lane (
            .clk      (clk),
            .rst      (rst),
            .start    (start),
            .act      (act[g*ACT_WIDTH +: ACT_WIDTH]),
            .add_en   (add_en),
            .add_sh   (add_sh),
            .fin      (last),
            .scale    (scale),
            .w_sign   (w_sign),
            .w_zero   (~w_sign & ~any_n),
            .w_nar    (w_sign & ~any_n),
            .sign_out (sign_out[g]),
            .exp_out  (exp_out[g*OEXP_W +: OEXP_W]),
            .mant_out (mant_out[g*MANT_OUT_W +: MANT_OUT_W]),
            .zero_out (zero_out[g]),
            .nar_out  (nar_out[g])
        );
    end

endmodule

// File: tb/tb_fp_posit_mul_vec.sv
// Directed table-driven bench for fp_posit_mul_vec at LANES=4, ES=0, PREC_MAX=8 (FRAC_MAX=5).
module tb_fp_posit_mul_vec;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        set = 1'b0;
    logic [3:0]  precision = 4'd0;
    logic [63:0] act = '0;
    logic        act_valid = 1'b0;
    logic        act_ready;
    logic        w = 1'b0;
    logic        w_valid = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [3:0]  sign_out;
    logic [35:0] exp_out;
    logic [63:0] mant_out;
    logic [3:0]  zero_out;
    logic [3:0]  nar_out;

    int total = 0;
    int bad = 0;

    typedef struct packed {
        logic [3:0][15:0] act;
        logic [7:0]       w;
        logic [3:0]       sg;
        logic [3:0][8:0]  ex;
        logic [3:0][15:0] mt;
        logic [3:0]       zr;
        logic [3:0]       nr;
    } vec_t;

    vec_t vt[$];
    vec_t v;

    fp_posit_mul_vec #(
        .LANES(4), .ACT_WIDTH(16), .EXP_WIDTH(5), .MAN_WIDTH(10), .PREC_MAX(8), .ES(0)
    ) dut (
        .clk(clk), .rst(rst), .set(set), .precision(precision),
        .act(act), .act_valid(act_valid), .act_ready(act_ready),
        .w(w), .w_valid(w_valid),
        .out_valid(out_valid), .out_ready(out_ready),
        .sign_out(sign_out), .exp_out(exp_out), .mant_out(mant_out),
        .zero_out(zero_out), .nar_out(nar_out)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, got, exp);
        end
    endtask

    function automatic vec_t bc(input logic [15:0] a, input logic [7:0] wv, input logic s,
                                input logic [8:0] e, input logic [15:0] m, input logic z, input logic n);
        vec_t r;
        r.act = {4{a}};
        r.w   = wv;
        r.sg  = {4{s}};
        r.ex  = {4{e}};
        r.mt  = {4{m}};
        r.zr  = {4{z}};
        r.nr  = {4{n}};
        return r;
    endfunction

    task automatic cmp_vec(input string tag, input vec_t e);
        chk({tag, " valid"}, out_valid, 1);
        chk({tag, " sign"}, sign_out, e.sg);
        chk({tag, " exp"}, exp_out, e.ex);
        chk({tag, " mant"}, mant_out, e.mt);
        chk({tag, " zero"}, zero_out, e.zr);
        chk({tag, " nar"}, nar_out, e.nr);
    endtask

    task automatic do_op(input string tag, input logic [63:0] a, input logic [14:0] bits,
                         input int nb, input int stall_at);
        int n;
        @(negedge clk);
        act = a;
        act_valid = 1'b1;
        n = 0;
        while (!act_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk({tag, " act_ready"}, act_ready, 1);
        @(negedge clk);
        act_valid = 1'b0;
        act = '0;
        for (int i = 0; i < nb; i++) begin
            if (i == stall_at) begin
                w_valid = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    w = ~bits[nb-1-i];
                    @(negedge clk);
                end
            end
            w = bits[nb-1-i];
            w_valid = 1'b1;
            @(negedge clk);
        end
        w_valid = 1'b0;
        w = 1'b0;
        chk({tag, " latency"}, out_valid, 1);
        n = 0;
        while (!out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic release_out(input string tag);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, " idle act_ready"}, act_ready, 1);
        chk({tag, " idle out_valid"}, out_valid, 0);
    endtask

    task automatic do_set(input logic [3:0] p);
        @(negedge clk);
        set = 1'b1;
        precision = p;
        @(negedge clk);
        set = 1'b0;
    endtask

    initial begin
        vt.push_back(bc(16'h3C00, 8'h40, 1'b0, 9'd15,  16'h8000, 1'b0, 1'b0));
        vt.push_back(bc(16'h3C00, 8'h60, 1'b0, 9'd16,  16'h8000, 1'b0, 1'b0));
        vt.push_back(bc(16'h3C00, 8'h20, 1'b0, 9'd14,  16'h8000, 1'b0, 1'b0));
        vt.push_back(bc(16'h3C00, 8'h50, 1'b0, 9'd15,  16'hC000, 1'b0, 1'b0));
        vt.push_back(bc(16'hBC00, 8'hC0, 1'b0, 9'd15,  16'h8000, 1'b0, 1'b0));
        vt.push_back(bc(16'h3C00, 8'hC0, 1'b1, 9'd15,  16'h8000, 1'b0, 1'b0));
        vt.push_back(bc(16'h3C00, 8'h00, 1'b0, 9'd0,   16'h0000, 1'b1, 1'b0));
        vt.push_back(bc(16'h3C00, 8'h80, 1'b1, 9'd0,   16'h0000, 1'b0, 1'b1));
        vt.push_back(bc(16'h3C00, 8'h7F, 1'b0, 9'd21,  16'h8000, 1'b0, 1'b0));
        vt.push_back(bc(16'h3C00, 8'h01, 1'b0, 9'd9,   16'h8000, 1'b0, 1'b0));
        vt.push_back(bc(16'h3C00, 8'h5F, 1'b0, 9'd15,  16'hFC00, 1'b0, 1'b0));
        vt.push_back(bc(16'h3C00, 8'h3F, 1'b0, 9'd14,  16'hFC00, 1'b0, 1'b0));
        vt.push_back(bc(16'h0400, 8'h10, 1'b0, 9'h1FF, 16'h8000, 1'b0, 1'b0));
        // Distinct lanes, one fraction bit at position 2.
        v.act = {16'h0400, 16'hC600, 16'h4200, 16'h3C00};
        v.w   = 8'h48;
        v.sg  = 4'b0100;
        v.ex  = {9'd1, 9'd17, 9'd16, 9'd15};
        v.mt  = {16'hA000, 16'hF000, 16'hF000, 16'hA000};
        v.zr  = 4'b0000;
        v.nr  = 4'b0000;
        vt.push_back(v);
        v.act = {16'h3C00, 16'h7C00, 16'h0000, 16'h3C00};
        v.w   = 8'h40;
        v.sg  = 4'b0000;
`ifdef FP_POSIT_ACT_SPECIAL_EN
        v.ex  = {9'd15, 9'd0, 9'd0, 9'd15};
        v.mt  = {16'h8000, 16'h0000, 16'h0000, 16'h8000};
        v.zr  = 4'b0010;
        v.nr  = 4'b0100;
`else
        v.ex  = {9'd15, 9'd31, 9'd0, 9'd15};
        v.mt  = {4{16'h8000}};
        v.zr  = 4'b0000;
        v.nr  = 4'b0000;
`endif
        vt.push_back(v);

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset out_valid", out_valid, 0);
        chk("reset act_ready", act_ready, 1);
        chk("reset exp", exp_out, 0);
        chk("reset mant", mant_out, 0);
        chk("reset flags", {sign_out, zero_out, nar_out}, 0);

        for (int i = 0; i < vt.size(); i++) begin
            do_op($sformatf("v%0d", i), vt[i].act, {7'b0, vt[i].w}, 8, -1);
            cmp_vec($sformatf("v%0d", i), vt[i]);
            release_out($sformatf("v%0d", i));
        end

        // Weight stall mid-fraction, then consumer back-pressure for 5 cycles.
        do_op("stall", vt[13].act, {7'b0, vt[13].w}, 8, 4);
        cmp_vec("stall", vt[13]);
        repeat (5) @(negedge clk);
        chk("hold act_ready", act_ready, 0);
        cmp_vec("hold", vt[13]);
        release_out("hold");

        // Precision below minimum clamps to 3 bits: sign, regime 1,0.
        do_set(4'd2);
        do_op("prec3", {4{16'h3C00}}, 15'b010, 3, -1);
        cmp_vec("prec3", bc(16'h3C00, 8'h00, 1'b0, 9'd15, 16'h8000, 1'b0, 1'b0));
        release_out("prec3");

        // 5-bit weight 1_01_10: negative, k=-1, fraction .10.
        do_set(4'd5);
        do_op("prec5", {4{16'h3C00}}, 15'b10110, 5, -1);
        cmp_vec("prec5", bc(16'h3C00, 8'h00, 1'b1, 9'd14, 16'hC000, 1'b0, 1'b0));
        release_out("prec5");

        // Reset in the middle of the regime run; stored precision returns to 8.
        @(negedge clk);
        act = {4{16'h3C00}};
        act_valid = 1'b1;
        @(negedge clk);
        act_valid = 1'b0;
        w_valid = 1'b1;
        w = 1'b0;
        @(negedge clk);
        w = 1'b1;
        @(negedge clk);
        w = 1'b1;
        @(negedge clk);
        w_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst out_valid", out_valid, 0);
        chk("midrst act_ready", act_ready, 1);
        chk("midrst exp", exp_out, 0);
        chk("midrst mant", mant_out, 0);
        do_op("postrst", vt[0].act, {7'b0, vt[0].w}, 8, -1);
        cmp_vec("postrst", vt[0]);
        release_out("postrst");

        // Precision above maximum clamps to 8.
        do_set(4'd12);
        do_op("prec12", vt[1].act, {7'b0, vt[1].w}, 8, -1);
        cmp_vec("prec12", vt[1]);
        release_out("prec12");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fp_posit_mul_vec.md
FP_POSIT_MUL_VEC -- requirements
Module: fp_posit_mul_vec

Interface
REQ-001 SHALL have parameter LANES, default 4: number of FP activation lanes sharing one serial weight stream.
REQ-002 SHALL have parameter ACT_WIDTH, default 16: FP activation width; EXP_WIDTH, default 5; MAN_WIDTH, default 10.
REQ-003 SHALL have parameter PREC_MAX, default 8: maximum posit weight width (3..15).
REQ-004 SHALL have parameter ES, default 0: posit exponent field width (0..2).
REQ-005 SHALL derive FRAC_MAX = PREC_MAX-3-ES, MANT_OUT_W = MAN_WIDTH+1+FRAC_MAX, OEXP_W = EXP_WIDTH+4 (signed).
REQ-006 SHALL have ports: clk in 1 clock; rst in 1 reset; set in 1 latch precision; precision in 4 posit width.
REQ-007 SHALL have ports: act in LANES*ACT_WIDTH (lane 0 in LSBs); act_valid in 1; act_ready out 1.
REQ-008 SHALL have ports: w in 1 weight bit, MSB first; w_valid in 1.
REQ-009 SHALL have ports: out_valid out 1; out_ready in 1; sign_out out LANES; exp_out out LANES*OEXP_W; mant_out out LANES*MANT_OUT_W; zero_out out LANES; nar_out out LANES.
REQ-010 SHALL use one clock, clk; reset rst is asynchronous and active-high.

Function
REQ-011 Weight format SHALL be sign bit, then posit magnitude encoding of |w| (regime, ES exponent bits, fraction); a negative weight is never two's complemented.
REQ-012 FSM states SHALL be IDLE, SIGN, REGIME, EXPO, FRAC, DONE; w is consumed only when w_valid=1 in SIGN..FRAC; w_valid=0 holds all state.
REQ-013 set SHALL be honoured only in IDLE; stored precision = clamp(precision, 3, PREC_MAX).
REQ-014 act_ready SHALL be 1 only in IDLE; act_valid&act_ready latches act and enters SIGN.
REQ-015 An operation SHALL consume exactly stored-precision weight bits, then enter DONE with out_valid=1 on the next cycle.
REQ-016 REGIME: run of m identical bits r ends at opposite bit or last bit; k = m-1 if r=1, else -m; the terminator is consumed in REGIME.
REQ-017 EXPO SHALL take up to ES bits MSB-first; bits not received before the end SHALL be zero.
REQ-018 FRAC: acc initialised to M<<FRAC_MAX (M = {1,act mantissa}); fraction bit i (1-based) = 1 adds M<<(FRAC_MAX-i); missing bits add nothing.
REQ-019 Per lane: sign_out = act sign ^ w sign; exp_out = act biased exponent + k*2^ES + e; mant_out = acc; no normalisation or rounding.
REQ-020 Weight all-zero SHALL set zero_out=1 all lanes; weight 1 followed by zeros SHALL set nar_out=1 all lanes; exp_out/mant_out then 0.
REQ-021 DONE SHALL hold outputs until out_valid&out_ready, then return to IDLE; throughput = precision+2 cycles minimum.

Reset
REQ-022 rst=1 SHALL force IDLE, act_ready=1 after release, out_valid=0, all data/flag outputs 0, stored precision = PREC_MAX, mid-operation data discarded.

Configuration
REQ-023 With FP_POSIT_ACT_SPECIAL_EN defined, per lane act exponent 0 SHALL force zero_out=1 and exponent all-ones SHALL force nar_out=1 (nar wins over zero); without it, act exponent is always treated as a normal number.

Structure
REQ-024 Package fp_posit_pkg SHALL hold the FSM state enum and derived-width constants.
REQ-025 Sub-module fp_posit_lane SHALL hold per-lane exponent add and mantissa accumulate; top holds shared FSM, counter, regime/exponent decode.

Verification (ES=0, PREC_MAX=8, precision=8)
REQ-026 act=0x3C00, w=0x40 -> exp_out=15, mant_out=0x8000, sign_out=0, flags 0.
REQ-027 act=0x3C00, w=0x60 -> exp_out=16; w=0x20 -> exp_out=14; mant_out=0x8000 both.
REQ-028 act=0x3C00, w=0x50 -> exp_out=15, mant_out=0xC000; act=0xBC00, w=0xC0 -> sign_out=0.
REQ-029 w=0x00 -> zero_out=1; w=0x80 -> nar_out=1; act=0x7C00 with FP_POSIT_ACT_SPECIAL_EN -> that lane nar_out=1.
REQ-030 w_valid low 3 cycles mid-FRAC -> result identical to no-stall run; out_ready low 5 cycles -> outputs stable, act_ready=0.
REQ-031 rst pulse mid-REGIME -> out_valid=0, IDLE; next operation with w=0x40 yields REQ-026 result.
